// File: rtl/alu_iterative.sv
// rtl/alu_iterative.sv - RV32-style ALU with a bit-serial shifter and valid/ready handshakes
module alu_iterative #(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             opcode_b5,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic [1:0]       ALU_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [SHAMT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_illegal;
    logic                 r_shr;
    logic                 r_sha;

    logic [WIDTH-1:0]     w_res;
    logic                 w_is_shift;
    logic                 w_shr;
    logic                 w_sha;
    logic                 w_illegal;
    logic [SHAMT_W-1:0]   w_shamt;
    logic                 w_start_iter;
    logic [WIDTH-1:0]     w_shift1;

    assign w_shamt = b[SHAMT_W-1:0];

    // Shifts only flag themselves here; w_res = a covers the zero-amount case.
    always_comb begin
        w_res      = '0;
        w_is_shift = 1'b0;
        w_shr      = 1'b0;
        w_sha      = 1'b0;
        w_illegal  = 1'b0;
        case (ALU_op)
            2'b00: w_res = a + b;
            2'b01: w_res = a - b;
            2'b10: begin
                case (funct3)
                    3'b000: w_res = (opcode_b5 & funct7b5) ? (a - b) : (a + b);
                    3'b001: begin
                        w_is_shift = 1'b1;
                        w_res      = a;
                    end
                    3'b010: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    3'b011: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
                    3'b100: w_res = a ^ b;
                    3'b101: begin
                        w_is_shift = 1'b1;
                        w_shr      = 1'b1;
                        w_sha      = funct7b5;
                        w_res      = a;
                    end
                    3'b110: w_res = a | b;
                    default: w_res = a & b;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_start_iter = w_is_shift && (w_shamt != '0);

    always_comb begin
        if (!r_shr)
            w_shift1 = {r_result[WIDTH-2:0], 1'b0};
        else
            w_shift1 = {(r_sha & r_result[WIDTH-1]), r_result[WIDTH-1:1]};
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_valid) w_next_state = w_start_iter ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == SHAMT_W'(1)) w_next_state = S_DONE;
            S_DONE:  if (result_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_shr     <= 1'b0;
            r_sha     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_illegal <= w_illegal;
                        r_shr     <= w_shr;
                        r_sha     <= w_sha;
                        r_result  <= w_res;
                        r_cnt     <= w_start_iter ? w_shamt : '0;
                    end
                end
                S_SHIFT: begin
                    r_result <= w_shift1;
                    r_cnt    <= r_cnt - SHAMT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign start_ready  = (r_state == S_IDLE);
    assign result_valid = (r_state == S_DONE);
    assign result       = r_result;
    assign zero         = result_valid && (r_result == '0);
    assign illegal      = result_valid && r_illegal;

endmodule

// File: tb/tb_alu_iterative.sv
// tb/tb_alu_iterative.sv - directed self-checking bench for alu_iterative
module tb_alu_iterative;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic        opcode_b5;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [1:0]  ALU_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_iterative #(.WIDTH(32)) dut (
        .clock        (clk),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .opcode_b5    (opcode_b5),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .ALU_op       (ALU_op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .zero         (zero),
        .illegal      (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one request at the negedge, waits for result_valid, samples, then releases it.
    task automatic do_op(input logic [1:0] op, input logic [2:0] f3, input logic ob5, input logic f7,
                         input logic [31:0] av, input logic [31:0] bv, input logic hold,
                         output logic [31:0] res, output int lat, output logic zr, output logic ill);
        @(negedge clk);
        ALU_op = op; funct3 = f3; opcode_b5 = ob5; funct7b5 = f7; a = av; b = bv;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        lat = 1;
        while (!result_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result; zr = zero; ill = illegal;
        if (!hold) begin
            @(negedge clk);
            result_ready = 1'b1;
            @(posedge clk);
            #1;
            result_ready = 1'b0;
        end
    endtask

    task automatic run_vec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                           input logic ob5, input logic f7, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_res, input int exp_lat, input logic exp_zero,
                           input logic exp_ill);
        logic [31:0] res;
        int          lat;
        logic        zr;
        logic        ill;
        do_op(op, f3, ob5, f7, av, bv, 1'b0, res, lat, zr, ill);
        check({tag, "_result"}, 64'(res), 64'(exp_res));
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_zero"}, 64'(zr), 64'(exp_zero));
        check({tag, "_illegal"}, 64'(ill), 64'(exp_ill));
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        zr;
        logic        ill;

        start_valid = 1'b0; result_ready = 1'b0;
        ALU_op = 2'b00; funct3 = 3'b000; opcode_b5 = 1'b0; funct7b5 = 1'b0;
        a = '0; b = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_start_ready", 64'(start_ready), 64'd1);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_vec("add_r",  2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 1, 1'b0, 1'b0);
        run_vec("sub_r",  2'b10, 3'b000, 1'b1, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 1'b0, 1'b0);
        run_vec("add_i",  2'b10, 3'b000, 1'b0, 1'b1, 32'd3, 32'd5, 32'd8, 1, 1'b0, 1'b0);
        run_vec("sub_op", 2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1, 1'b1, 1'b0);
        run_vec("add_op", 2'b00, 3'b111, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1, 1'b0, 1'b0);
        run_vec("sra4",   2'b10, 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 1'b0, 1'b0);
        run_vec("srl4",   2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 5, 1'b0, 1'b0);
        run_vec("sll0",   2'b10, 3'b001, 1'b1, 1'b0, 32'd1, 32'd0, 32'd1, 1, 1'b0, 1'b0);
        run_vec("sll31",  2'b10, 3'b001, 1'b1, 1'b0, 32'd1, 32'd31, 32'h8000_0000, 32, 1'b0, 1'b0);
        run_vec("slt",    2'b10, 3'b010, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0, 1'b0);
        run_vec("sltu",   2'b10, 3'b011, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b1, 1'b0);
        run_vec("xor",    2'b10, 3'b100, 1'b1, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1, 1'b0, 1'b0);
        run_vec("or",     2'b10, 3'b110, 1'b1, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1, 1'b0, 1'b0);
        run_vec("and",    2'b10, 3'b111, 1'b1, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1, 1'b0, 1'b0);
        run_vec("illop",  2'b11, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 1, 1'b1, 1'b1);

        // Back-pressure: result must hold while new requests are ignored.
        do_op(2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 1'b1, res, lat, zr, ill);
        check("hold_first", 64'(res), 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_valid = 1'b1; a = 32'd100 + 32'(i); b = 32'd1;
            @(posedge clk);
            #1;
            check("hold_result", 64'(result), 64'd3);
            check("hold_valid", 64'(result_valid), 64'd1);
            check("hold_start_ready", 64'(start_ready), 64'd0);
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0; result_ready = 1'b0;
        check("release_valid", 64'(result_valid), 64'd0);
        check("release_start_ready", 64'(start_ready), 64'd1);
        check("release_result", 64'(result), 64'd3);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        ALU_op = 2'b10; funct3 = 3'b001; opcode_b5 = 1'b1; funct7b5 = 1'b0;
        a = 32'd1; b = 32'd31; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #2;
        check("pre_rst_busy", 64'(start_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 64'(result_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_start_ready", 64'(start_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec("post_rst_add", 2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd12, 1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_iterative.md
ALU_ITERATIVE -- requirements
Module: alu_iterative

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH), shift-amount width; SHALL be derived from WIDTH, never overridden.
REQ-003 clock  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start_valid  in  1  operation request valid.
REQ-006 start_ready  out  1  block can accept a request.
REQ-007 opcode_b5  in  1  instruction opcode bit 5 (1 = R-type).
REQ-008 funct3  in  3  instruction funct3.
REQ-009 funct7b5  in  1  instruction funct7 bit 5.
REQ-010 ALU_op  in  2  main-decoder class: 00 add, 01 sub, 10 funct-decoded, 11 reserved.
REQ-011 a, b  in  WIDTH each  operands; b[SHAMT_W-1:0] is the shift amount.
REQ-012 result_valid  out  1  result available.
REQ-013 result_ready  in  1  consumer accepts result.
REQ-014 result  out  WIDTH  registered result.
REQ-015 zero  out  1  high when result == 0, qualified by result_valid.
REQ-016 illegal  out  1  high with result_valid when the operation was undecodable.

Function
REQ-017 Decode: ALU_op 00 = add; ALU_op 01 = sub; ALU_op 10 selects by funct3:
- 000: sub if opcode_b5 & funct7b5, else add.
- 001: sll.
- 010: slt, signed.
- 011: sltu.
- 100: xor.
- 101: sra if funct7b5, else srl.
- 110: or.
- 111: and.
REQ-018 ALU_op 11 SHALL complete as an ordinary operation with result 0 and illegal = 1.
REQ-019 Add/sub SHALL wrap modulo 2^WIDTH; slt/sltu SHALL return 1 or 0 zero-extended to WIDTH.
REQ-020 FSM states: IDLE, SHIFT, DONE; start_ready SHALL be 1 only in IDLE.
REQ-021 Accept occurs when start_valid & start_ready; all inputs SHALL be captured then and ignored until the next accept.
REQ-022 From IDLE on accept:
- Non-shift op or shift amount 0: compute result, go to DONE; result_valid rises on the next cycle (latency 1).
- Shift op with amount N > 0: load operand and counter N, go to SHIFT.
REQ-023 In SHIFT, each cycle SHALL shift one bit (sra replicates the MSB) and decrement the counter; on reaching 0 the FSM goes to DONE. Result_valid SHALL rise exactly 1+N cycles after accept.
REQ-024 In DONE, result_valid = 1 and result, zero and illegal SHALL hold stable until result_ready = 1; on that edge the FSM returns to IDLE.
REQ-025 No new request SHALL be accepted in the DONE cycle in which result_ready is high; start_ready returns on the following cycle.
REQ-026 start_valid in SHIFT or DONE SHALL have no effect.
REQ-027 Maximum latency SHALL be WIDTH cycles (shift by WIDTH-1).

Reset
REQ-028 reset_n low SHALL immediately force, without waiting for a clock edge:
- FSM to IDLE, counter to 0.
- result to 0, result_valid to 0, illegal to 0, zero to 0.
- start_ready to 1.
REQ-029 Reset during SHIFT or DONE SHALL discard the in-flight operation, with no result delivered.
REQ-030 First accept SHALL be possible on the first rising edge with reset_n high.

Verification
REQ-031 Bench SHALL use WIDTH=32 and cover at least the following:
- a=5, b=7, ALU_op=10, funct3=000, opcode_b5=1, funct7b5=0 -> result=12, zero=0, valid 1 cycle after accept.
- a=3, b=5, funct3=000, opcode_b5=1, funct7b5=1 -> 0xFFFFFFFE; same with opcode_b5=0 -> 8; ALU_op=01, a=b=9 -> 0, zero=1.
- a=0x80000000, b=4, funct3=101, funct7b5=1 -> 0xF8000000, valid 5 cycles after accept; funct7b5=0 -> 0x08000000; funct3=001, a=1, b=0 -> 1 with latency 1.
- a=0xFFFFFFFF, b=1: funct3=010 -> 1, funct3=011 -> 0; ALU_op=11 -> result=0, illegal=1.
- result_ready held low 3 cycles in DONE -> result and valid stable, start_ready=0, start_valid ignored; release -> start_ready=1 next cycle.
- Shift with b=31 and reset_n pulsed low 10 cycles after accept -> valid=0, result=0 at once, start_ready=1, next add completes correctly.
